pixel_out_mux: RTL and testbench

Parametrised final-stage VGA pixel selector for the passport pipeline. It sits between the colour-processing chain (ycrcb2rgb → rgb2hsv → enhance → hsv2rgb → filters) plus the frame-buffer BRAM read path, and the VGA pins. It realigns hsync/vsync/blank to the chain's latency and chooses among `NUM_SRC` live 24-bit RGB sources and one RGB332 frame-buffer source. Source changes take effect only at a frame boundary, so a switch never tears mid-frame.

---
 rtl/pixel_out_pkg.sv | 41 ++++
 rtl/sync_delay_line.sv | 33 +++
 rtl/pixel_out_mux.sv | 137 +++++++++++++
 tb/tb_pixel_out_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_out_pkg.sv
// Shared constants, timing payload and helpers for the final VGA pixel selector.
// The default sync latency is the sum of the colour chain stage latencies.
package pixel_out_pkg;

    localparam int unsigned YCRCB2RGB_DLY = 4;
    localparam int unsigned RGB2HSV_DLY   = 23;
    localparam int unsigned THRESHOLD_DLY = 1;
    localparam int unsigned HSV2RGB_DLY   = 10;
    localparam int unsigned ENHANCE_DLY   = 1;
    localparam int unsigned SEPIA_DLY     = 4;
    localparam int unsigned INVERT_DLY    = 1;

    // Latency of the default chain: ycrcb2rgb, rgb2hsv, threshold, hsv2rgb, enhance, sepia.
    localparam int unsigned DEFAULT_SYNC_DLY = YCRCB2RGB_DLY + RGB2HSV_DLY + THRESHOLD_DLY
                                             + HSV2RGB_DLY + ENHANCE_DLY + SEPIA_DLY;

    localparam int unsigned RGB_W       = 24;
    localparam int unsigned FB_W        = 8;
    localparam int unsigned HCOUNT_W    = 11;
    localparam int unsigned VCOUNT_W    = 10;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic in_win;
    } vga_timing_t;

    localparam int unsigned TIMING_W = $bits(vga_timing_t);

    // Selector width: live codes 0..num_src-1 plus one frame-buffer code.
    function automatic int unsigned sel_width(input int unsigned num_src);
        return $clog2(num_src + 1);
    endfunction

    function automatic logic [RGB_W-1:0] rgb332_to_rgb888(input logic [FB_W-1:0] px);
        return {px[7:5], 5'b0, px[4:2], 5'b0, px[1:0], 6'b0};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Synchronous-reset shift register exposing taps DEPTH-1 and DEPTH.
// DEPTH must be at least 2.
module sync_delay_line #(
    parameter int unsigned     WIDTH     = 4,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] tap_pre_o,
    output logic [WIDTH-1:0] tap_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tap_pre_o = stage_q[DEPTH-2];
    assign tap_o     = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_out_mux.sv
// Final-stage VGA pixel selector: realigns sync to the colour chain latency and
// switches among live sources and the RGB332 frame buffer only at frame boundaries.
module pixel_out_mux
    import pixel_out_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned SYNC_DLY      = DEFAULT_SYNC_DLY,
    parameter int unsigned DISP_W        = 640,
    parameter int unsigned DISP_H        = 400,
    parameter logic [23:0] BORDER_RGB    = 24'hFFFFFF,
    parameter bit          VSYNC_ACT_LOW = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [sel_width(NUM_SRC)-1:0]     src_req,
    input  logic                              mute,
    input  logic [RGB_W*NUM_SRC-1:0]          src_pixel,
    input  logic [FB_W-1:0]                   fb_pixel,
    input  logic [HCOUNT_W-1:0]               hcount,
    input  logic [VCOUNT_W-1:0]               vcount,
    input  logic                              hsync,
    input  logic                              vsync,
    input  logic                              blank,
    output logic [RGB_W-1:0]                  pixel_out,
    output logic                              hsync_out,
    output logic                              vsync_out,
    output logic                              blank_out,
    output logic [sel_width(NUM_SRC)-1:0]     active_sel,
    output logic                              switch_pending,
    output logic [FRAME_CNT_W-1:0]            frame_cnt
);

    localparam int unsigned      SEL_W     = sel_width(NUM_SRC);
    localparam logic [SEL_W-1:0] FB_CODE   = SEL_W'(NUM_SRC);
    localparam logic             SYNC_IDLE = VSYNC_ACT_LOW;
    localparam int unsigned      FLUSH_W   = $clog2(SYNC_DLY + 1);
    localparam vga_timing_t      TIMING_IDLE = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE,
                                                 blank: 1'b1, in_win: 1'b0};

    vga_timing_t timing_raw;
    vga_timing_t timing_pre;
    vga_timing_t timing_dly;

    logic [SEL_W-1:0]       pending_q, pending_d;
    logic [SEL_W-1:0]       active_q, active_d;
    logic                   switch_pending_q, switch_pending_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [RGB_W-1:0]       pixel_q, pixel_d;
    logic [RGB_W-1:0]       live_px;
    logic                   req_legal;
    logic                   flushed;
    logic                   frame_bnd;

    // Window membership is judged on the raw counters and then travels with the sync bits.
    always_comb begin
        timing_raw        = TIMING_IDLE;
        timing_raw.hsync  = hsync;
        timing_raw.vsync  = vsync;
        timing_raw.blank  = blank;
        timing_raw.in_win = (hcount < HCOUNT_W'(DISP_W)) && (vcount < VCOUNT_W'(DISP_H));
    end

    sync_delay_line #(
        .WIDTH     (TIMING_W),
        .DEPTH     (SYNC_DLY),
        .RESET_VAL (TIMING_IDLE)
    ) u_sync_dly (
        .clk       (clk),
        .reset     (reset),
        .data_i    (timing_raw),
        .tap_pre_o (timing_pre),
        .tap_o     (timing_dly)
    );

    // Frame boundary is only trusted once both compared taps hold post-reset timing.
    assign flushed = (flush_cnt_q == FLUSH_W'(SYNC_DLY));

    always_comb begin
        req_legal        = (src_req <= FB_CODE);
        pending_d        = req_legal ? src_req : pending_q;
        frame_bnd        = flushed && (timing_dly.vsync == SYNC_IDLE)
                                   && (timing_pre.vsync != SYNC_IDLE);
        active_d         = frame_bnd ? pending_d : active_q;
        frame_cnt_d      = frame_bnd ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
        switch_pending_d = (pending_d != active_d);
        flush_cnt_d      = flushed ? flush_cnt_q : flush_cnt_q + FLUSH_W'(1);

        live_px = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (active_d == SEL_W'(k)) begin
                live_px = src_pixel[RGB_W*k +: RGB_W];
            end
        end

        // The new source already drives the first pixel of the sync-pulse line.
        if (mute) begin
            pixel_d = '0;
        end else if (timing_pre.blank) begin
            pixel_d = '0;
        end else if (active_d == FB_CODE) begin
            pixel_d = timing_pre.in_win ? rgb332_to_rgb888(fb_pixel) : BORDER_RGB;
        end else begin
            pixel_d = live_px;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q        <= '0;
            active_q         <= '0;
            switch_pending_q <= 1'b0;
            frame_cnt_q      <= '0;
            flush_cnt_q      <= '0;
            pixel_q          <= '0;
        end else begin
            pending_q        <= pending_d;
            active_q         <= active_d;
            switch_pending_q <= switch_pending_d;
            frame_cnt_q      <= frame_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
            pixel_q          <= pixel_d;
        end
    end

    assign pixel_out      = pixel_q;
    assign hsync_out      = timing_dly.hsync;
    assign vsync_out      = timing_dly.vsync;
    assign blank_out      = timing_dly.blank;
    assign active_sel     = active_q;
    assign switch_pending = switch_pending_q;
    assign frame_cnt      = frame_cnt_q;

    logic unused_timing;
    assign unused_timing = ^{timing_pre.hsync, timing_dly.in_win};

endmodule

// File: tb/tb_pixel_out_mux.sv
// Randomised bench for pixel_out_mux against a cycle-history reference model.
module tb_pixel_out_mux;

    localparam int NSRC = 2;
    localparam int DLY  = 43;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  src_req;
    logic        mute;
    logic [47:0] src_pixel;
    logic [7:0]  fb_pixel;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank;
    logic [23:0] pixel_out;
    logic        hsync_out, vsync_out, blank_out;
    logic [1:0]  active_sel;
    logic        switch_pending;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    pixel_out_mux #(
        .NUM_SRC       (NSRC),
        .SYNC_DLY      (DLY),
        .DISP_W        (640),
        .DISP_H        (400),
        .BORDER_RGB    (24'hFFFFFF),
        .VSYNC_ACT_LOW (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_req        (src_req),
        .mute           (mute),
        .src_pixel      (src_pixel),
        .fb_pixel       (fb_pixel),
        .hcount         (hcount),
        .vcount         (vcount),
        .hsync          (hsync),
        .vsync          (vsync),
        .blank          (blank),
        .pixel_out      (pixel_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .blank_out      (blank_out),
        .active_sel     (active_sel),
        .switch_pending (switch_pending),
        .frame_cnt      (frame_cnt)
    );

    typedef struct {
        logic        rst;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        mute;
        logic [47:0] src;
        logic [7:0]  fbp;
        logic [1:0]  req;
    } rec_t;

    rec_t hist [NCYC];

    int n_checks = 0;
    int n_errors = 0;

    int          m_pend;
    int          m_act;
    int          m_fcnt;
    logic [23:0] m_pix;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycles before the run started count as reset with idle timing.
    function automatic rec_t rec_at(input int idx);
        rec_t r;
        if (idx < 0) begin
            r.rst = 1'b1; r.hs = 1'b1; r.vs = 1'b1; r.bl = 1'b1;
            r.hc = '0; r.vc = '0; r.mute = 1'b0; r.src = '0; r.fbp = '0; r.req = '0;
        end else begin
            r = hist[idx];
        end
        return r;
    endfunction

    function automatic bit rst_free(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (rec_at(i).rst) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [23:0] expand332(input logic [7:0] p);
        int r, g, b;
        r = int'(p) / 32;
        g = (int'(p) / 4) % 8;
        b = int'(p) % 4;
        return 24'(r * (2 ** 21) + g * (2 ** 13) + b * (2 ** 6));
    endfunction

    // Effect of the clock edge that ends cycle c-1.
    task automatic model_step(input int c);
        rec_t r, t, t_prev;
        int   p, nxt;
        bit   tv, fb;
        p = c - 1;
        r = rec_at(p);
        if (r.rst) begin
            m_pend = 0; m_act = 0; m_fcnt = 0; m_pix = '0;
        end else begin
            t      = rec_at(p - DLY + 1);
            t_prev = rec_at(p - DLY);
            tv     = rst_free(p - DLY + 1, p);
            fb     = rst_free(p - DLY, p) && (t_prev.vs == 1'b1) && (t.vs == 1'b0);
            nxt    = (int'(r.req) <= NSRC) ? int'(r.req) : m_pend;
            if (fb) begin
                m_act  = nxt;
                m_fcnt = (m_fcnt + 1) % 65536;
            end
            m_pend = nxt;
            if (r.mute || !tv || t.bl) begin
                m_pix = '0;
            end else if (m_act == NSRC) begin
                m_pix = (int'(t.hc) < 640 && int'(t.vc) < 400) ? expand332(r.fbp) : 24'hFFFFFF;
            end else begin
                m_pix = r.src[24*m_act +: 24];
            end
        end
    endtask

    task automatic check_cycle(input int c);
        rec_t s;
        bit   sv;
        sv = rst_free(c - DLY, c - 1);
        s  = rec_at(c - DLY);
        check_eq($sformatf("c%0d pixel_out", c), 32'(pixel_out), 32'(m_pix));
        check_eq($sformatf("c%0d hsync_out", c), 32'(hsync_out), sv ? 32'(s.hs) : 32'd1);
        check_eq($sformatf("c%0d vsync_out", c), 32'(vsync_out), sv ? 32'(s.vs) : 32'd1);
        check_eq($sformatf("c%0d blank_out", c), 32'(blank_out), sv ? 32'(s.bl) : 32'd1);
        check_eq($sformatf("c%0d active_sel", c), 32'(active_sel), 32'(m_act));
        check_eq($sformatf("c%0d switch_pending", c), 32'(switch_pending),
                 (m_pend != m_act) ? 32'd1 : 32'd0);
        check_eq($sformatf("c%0d frame_cnt", c), 32'(frame_cnt), 32'(m_fcnt));
    endtask

    // Compressed frame: 40-cycle lines, 200-cycle frames, vsync low for 5 cycles.
    task automatic gen_inputs(input int c);
        rec_t r;
        int   ph, fpos, lpos;
        ph   = c / 600;
        fpos = c % 200;
        lpos = c % 40;
        r.rst = (c < 3) || (c == 2181) || (c == 2182) || (c == 3224) || (c == 3225);
        r.vs  = !(fpos >= 180 && fpos < 185);
        r.bl  = (fpos >= 170) || (lpos >= 34);
        r.hs  = !(lpos >= 36 && lpos < 39);
        r.hc  = ($urandom_range(0, 3) == 0) ? 11'(638 + $urandom_range(0, 3))
                                             : 11'($urandom_range(0, 799));
        r.vc  = ($urandom_range(0, 3) == 0) ? 10'(398 + $urandom_range(0, 3))
                                             : 10'($urandom_range(0, 524));
        r.src  = {16'($urandom()), $urandom()};
        r.fbp  = 8'($urandom());
        r.mute = ($urandom_range(0, 15) == 0);
        case (ph)
            0:       r.req = 2'd0;
            1:       r.req = 2'd1;
            2:       r.req = 2'd2;
            3:       r.req = 2'd3;
            5:       r.req = 2'd1;
            default: r.req = 2'($urandom_range(0, 3));
        endcase
        if (ph == 2 && $urandom_range(0, 3) == 0) begin
            r.fbp = 8'hE3; r.hc = 11'd100; r.vc = 10'd50;
        end
        if (ph == 5) begin
            r.src[47:24] = 24'h123456;
            r.mute       = ($urandom_range(0, 3) == 0);
        end
        hist[c]   = r;
        reset     = r.rst;
        hsync     = r.hs;
        vsync     = r.vs;
        blank     = r.bl;
        hcount    = r.hc;
        vcount    = r.vc;
        mute      = r.mute;
        src_pixel = r.src;
        fb_pixel  = r.fbp;
        src_req   = r.req;
    endtask

    initial begin
        reset = 1'b1; src_req = '0; mute = 1'b0; src_pixel = '0; fb_pixel = '0;
        hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        m_pend = 0; m_act = 0; m_fcnt = 0; m_pix = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            model_step(c);
            check_cycle(c);
            gen_inputs(c);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
